// File: rtl/wishbone_voice_regs.sv
`default_nettype none
// ============================================================================
// wishbone_voice_regs : Wishbone B4-classic register bank for the multi-voice
//                       synth. Per-voice parameters with shadow/commit.
// Revision: 1.0
// ============================================================================
module wishbone_voice_regs #(
  parameter int          NUM_VOICES    = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter bit          SHADOW        = 1'b1,
  parameter logic [15:0] I2S_DIV_RESET = 16'd32
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_dat_i,
  input  logic [31:0]                wbs_adr_i,
  output logic                       wbs_ack_o,
  output logic                       wbs_err_o,
  output logic [31:0]                wbs_dat_o,
  output logic [32*NUM_VOICES-1:0]   divisor,
  output logic [8*NUM_VOICES-1:0]    duty,
  output logic [27*NUM_VOICES-1:0]   attack,
  output logic [27*NUM_VOICES-1:0]   decay,
  output logic [27*NUM_VOICES-1:0]   fade,
  output logic [16*NUM_VOICES-1:0]   sustain,
  output logic [18*NUM_VOICES-1:0]   cutoff,
  output logic [18*NUM_VOICES-1:0]   resonance,
  output logic [NUM_VOICES-1:0]      waveform,
  output logic [NUM_VOICES-1:0]      trigger,
  output logic [15:0]                i2s_divisor
);

  typedef struct packed {
    logic [31:0] div;
    logic [7:0]  duty;
    logic [26:0] attack;
    logic [15:0] sustain;
    logic [26:0] decay;
    logic [26:0] fade;
    logic [17:0] cutoff;
    logic [17:0] res;
  } voice_t;

  localparam logic [2:0]  NV3   = 3'(NUM_VOICES);
  localparam logic [31:0] ID_WORD = {16'h5359, 8'h00, 8'(NUM_VOICES)};

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  logic                         ack_q, ack_d, err_q, err_d;
  logic [31:0]                  dat_q, dat_d;
  logic [NUM_VOICES-1:0]        trig_q, trig_d;
  voice_t [NUM_VOICES-1:0]      sh_q, sh_d;
  logic [NUM_VOICES-1:0]        wave_sh_q, wave_sh_d;
  logic [15:0]                  i2s_q, i2s_d;
  voice_t [NUM_VOICES-1:0]      live;
  logic [NUM_VOICES-1:0]        live_wave;

  logic [2:0]  block, word;
  logic        addr_hit, is_voice, is_global, mapped, resp_ok, do_write, is_cmd, commit;
  logic [31:0] rd_val, wr_val;
  logic        unused_ok;

  assign unused_ok = &{1'b0, wbs_adr_i[1:0]};
  assign block     = wbs_adr_i[7:5];
  assign word      = wbs_adr_i[4:2];
  assign addr_hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign is_voice  = block < NV3;
  assign is_global = (block == 3'd7);
  assign mapped    = addr_hit && (is_voice ||
                     (is_global && !word[2] && !(wbs_we_i && word == 3'd3)));
  // Only one response per request, and a one-cycle gap before the next
  assign resp_ok   = wbs_stb_i && wbs_cyc_i && !ack_q && !err_q;
  assign ack_d     = resp_ok && mapped;
  assign err_d     = resp_ok && !mapped;
  assign do_write  = ack_d && wbs_we_i;
  assign is_cmd    = is_global && (word == 3'd1);
  assign commit    = do_write && is_cmd && wbs_sel_i[0] && wbs_dat_i[0];
  assign trig_d    = (do_write && is_cmd && wbs_sel_i[1]) ? wbs_dat_i[8 +: NUM_VOICES] : '0;
  assign dat_d     = resp_ok ? (mapped ? rd_val : 32'd0) : dat_q;

  always_comb begin
    rd_val = '0;
    if (is_global) begin
      case (word)
        3'd0:    rd_val = 32'(wave_sh_q);
        3'd2:    rd_val = {16'd0, i2s_q};
        3'd3:    rd_val = ID_WORD;
        default: rd_val = '0;
      endcase
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (block == 3'(v)) begin
          case (word)
            3'd0:    rd_val = sh_q[v].div;
            3'd1:    rd_val = 32'(sh_q[v].duty);
            3'd2:    rd_val = 32'(sh_q[v].attack);
            3'd3:    rd_val = 32'(sh_q[v].sustain);
            3'd4:    rd_val = 32'(sh_q[v].decay);
            3'd5:    rd_val = 32'(sh_q[v].fade);
            3'd6:    rd_val = 32'(sh_q[v].cutoff);
            default: rd_val = 32'(sh_q[v].res);
          endcase
        end
      end
    end
  end

  // Byte-merge against the current value, then keep only implemented bits
  assign wr_val = merge(rd_val, wbs_dat_i, wbs_sel_i);

  always_comb begin
    sh_d      = sh_q;
    wave_sh_d = wave_sh_q;
    i2s_d     = i2s_q;
    if (do_write) begin
      if (is_global) begin
        if (word == 3'd0) wave_sh_d = wr_val[NUM_VOICES-1:0];
        if (word == 3'd2) i2s_d     = wr_val[15:0];
      end else begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (block == 3'(v)) begin
            case (word)
              3'd0:    sh_d[v].div     = wr_val;
              3'd1:    sh_d[v].duty    = wr_val[7:0];
              3'd2:    sh_d[v].attack  = wr_val[26:0];
              3'd3:    sh_d[v].sustain = wr_val[15:0];
              3'd4:    sh_d[v].decay   = wr_val[26:0];
              3'd5:    sh_d[v].fade    = wr_val[26:0];
              3'd6:    sh_d[v].cutoff  = wr_val[17:0];
              default: sh_d[v].res     = wr_val[17:0];
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      trig_q    <= '0;
      sh_q      <= '0;
      wave_sh_q <= '0;
      i2s_q     <= I2S_DIV_RESET;
    end else begin
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      trig_q    <= trig_d;
      sh_q      <= sh_d;
      wave_sh_q <= wave_sh_d;
      i2s_q     <= i2s_d;
    end
  end

  if (SHADOW) begin : g_shadow
    voice_t [NUM_VOICES-1:0] out_q, out_d;
    logic [NUM_VOICES-1:0]   wave_out_q, wave_out_d;

    always_comb begin
      out_d      = out_q;
      wave_out_d = wave_out_q;
      if (commit) begin
        out_d      = sh_q;
        wave_out_d = wave_sh_q;
      end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        out_q      <= '0;
        wave_out_q <= '0;
      end else begin
        out_q      <= out_d;
        wave_out_q <= wave_out_d;
      end
    end

    assign live      = out_q;
    assign live_wave = wave_out_q;
  end else begin : g_direct
    assign live      = sh_q;
    assign live_wave = wave_sh_q;
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_port
    assign divisor[32*v +: 32]   = live[v].div;
    assign duty[8*v +: 8]        = live[v].duty;
    assign attack[27*v +: 27]    = live[v].attack;
    assign decay[27*v +: 27]     = live[v].decay;
    assign fade[27*v +: 27]      = live[v].fade;
    assign sustain[16*v +: 16]   = live[v].sustain;
    assign cutoff[18*v +: 18]    = live[v].cutoff;
    assign resonance[18*v +: 18] = live[v].res;
  end

  assign waveform    = live_wave;
  assign trigger     = trig_q;
  assign i2s_divisor = i2s_q;
  assign wbs_ack_o   = ack_q;
  assign wbs_err_o   = err_q;
  assign wbs_dat_o   = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_voice_regs.sv
`default_nettype none
// ============================================================================
// tb_wishbone_voice_regs : directed + random bus traffic against a word-level
//                          register model of the voice register bank.
// Revision: 1.0
// ============================================================================
module tb_wishbone_voice_regs;
  localparam int NV = 4;

  logic clk = 1'b0;
  logic rst, stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack, err;
  logic [31:0] dat_o;
  logic [32*NV-1:0] divisor;
  logic [8*NV-1:0]  duty;
  logic [27*NV-1:0] attack, decay, fade;
  logic [16*NV-1:0] sustain;
  logic [18*NV-1:0] cutoff, resonance;
  logic [NV-1:0]    waveform, trigger;
  logic [15:0]      i2s_divisor;

  always #5 clk = ~clk;

  wishbone_voice_regs #(.NUM_VOICES(NV)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_err_o(err), .wbs_dat_o(dat_o),
    .divisor(divisor), .duty(duty), .attack(attack), .decay(decay), .fade(fade),
    .sustain(sustain), .cutoff(cutoff), .resonance(resonance),
    .waveform(waveform), .trigger(trigger), .i2s_divisor(i2s_divisor)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word-level model: each register is a 32-bit word masked to its field width
  logic [31:0]   m_sh  [NV][8];
  logic [31:0]   m_out [NV][8];
  logic [NV-1:0] m_wave_sh, m_wave_out;
  logic [15:0]   m_i2s;
  logic [31:0]   m_dat;
  int            fw [8] = '{32, 8, 27, 16, 27, 27, 18, 18};
  localparam logic [31:0] ID_WORD = {16'h5359, 8'h00, 8'(NV)};

  function automatic logic [31:0] fmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] bytes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++)
      for (int w = 0; w < 8; w++) begin
        m_sh[v][w]  = '0;
        m_out[v][w] = '0;
      end
    m_wave_sh = '0; m_wave_out = '0; m_i2s = 16'd32; m_dat = '0;
  endtask

  task automatic check_outputs(input string tag);
    logic [32*NV-1:0] e_div; logic [8*NV-1:0] e_duty;
    logic [27*NV-1:0] e_att, e_dec, e_fade; logic [16*NV-1:0] e_sus;
    logic [18*NV-1:0] e_cut, e_res;
    for (int v = 0; v < NV; v++) begin
      e_div[32*v +: 32]  = m_out[v][0];
      e_duty[8*v +: 8]   = m_out[v][1][7:0];
      e_att[27*v +: 27]  = m_out[v][2][26:0];
      e_sus[16*v +: 16]  = m_out[v][3][15:0];
      e_dec[27*v +: 27]  = m_out[v][4][26:0];
      e_fade[27*v +: 27] = m_out[v][5][26:0];
      e_cut[18*v +: 18]  = m_out[v][6][17:0];
      e_res[18*v +: 18]  = m_out[v][7][17:0];
    end
    check_val({tag, ".divisor"}, 256'(divisor), 256'(e_div));
    check_val({tag, ".duty"}, 256'(duty), 256'(e_duty));
    check_val({tag, ".attack"}, 256'(attack), 256'(e_att));
    check_val({tag, ".sustain"}, 256'(sustain), 256'(e_sus));
    check_val({tag, ".decay"}, 256'(decay), 256'(e_dec));
    check_val({tag, ".fade"}, 256'(fade), 256'(e_fade));
    check_val({tag, ".cutoff"}, 256'(cutoff), 256'(e_cut));
    check_val({tag, ".resonance"}, 256'(resonance), 256'(e_res));
    check_val({tag, ".waveform"}, 256'(waveform), 256'(m_wave_out));
    check_val({tag, ".i2s"}, 256'(i2s_divisor), 256'(m_i2s));
  endtask

  // One complete bus access, checked against the model on the response edge
  task automatic xfer(input string tag, input logic w_en, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int blk = int'(a[7:5]);
    int wd  = int'(a[4:2]);
    bit hit = (a[31:8] == 24'h30_0000);
    bit mp  = hit && (blk < NV || (blk == 7 && wd < 4 && !(w_en && wd == 3)));
    logic [31:0]   rd = '0;
    logic [NV-1:0] e_trig = '0;
    if (blk < NV) rd = m_sh[blk][wd];
    else if (blk == 7 && wd == 0) rd = 32'(m_wave_sh);
    else if (blk == 7 && wd == 2) rd = {16'd0, m_i2s};
    else if (blk == 7 && wd == 3) rd = ID_WORD;

    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w_en; adr = a; dat_i = d; sel = s;
    @(posedge clk); #1;
    m_dat = mp ? rd : 32'd0;
    if (mp && w_en) begin
      if (blk < NV) m_sh[blk][wd] = bytes(m_sh[blk][wd], d, s) & fmask(fw[wd]);
      else if (wd == 0) m_wave_sh = NV'(bytes(32'(m_wave_sh), d, s));
      else if (wd == 2) m_i2s = 16'(bytes({16'd0, m_i2s}, d, s));
      else if (wd == 1) begin
        if (s[1]) e_trig = d[8 +: NV];
        if (s[0] && d[0]) begin
          m_out = m_sh;
          m_wave_out = m_wave_sh;
        end
      end
    end
    check_val({tag, ".ack"}, 256'(ack), 256'(mp));
    check_val({tag, ".err"}, 256'(err), 256'(!mp));
    check_val({tag, ".dat"}, 256'(dat_o), 256'(m_dat));
    check_val({tag, ".trig"}, 256'(trigger), 256'(e_trig));
    check_outputs(tag);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check_val({tag, ".ack_off"}, 256'({ack, err}), 256'(0));
    check_val({tag, ".trig_off"}, 256'(trigger), 256'(0));
    check_val({tag, ".dat_hold"}, 256'(dat_o), 256'(m_dat));
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; dat_i = '0; adr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset.resp", 256'({ack, err, dat_o, trigger}), 256'(0));
    check_outputs("reset");
    @(negedge clk) rst = 1'b0;

    xfer("rd_id", 1'b0, 32'h3000_00EC, '0, 4'hF);
    check_val("rd_id.value", 256'(dat_o), 256'(32'h5359_0004));
    xfer("rd_i2s", 1'b0, 32'h3000_00E8, '0, 4'hF);
    check_val("rd_i2s.value", 256'(dat_o), 256'(32));

    xfer("wr_div1", 1'b1, 32'h3000_0020, 32'h0001_2345, 4'hF);
    check_val("wr_div1.unshadowed", 256'(divisor[63:32]), 256'(0));
    xfer("rd_div1", 1'b0, 32'h3000_0020, '0, 4'hF);
    check_val("rd_div1.value", 256'(dat_o), 256'(32'h0001_2345));
    xfer("commit1", 1'b1, 32'h3000_00E4, 32'h1, 4'hF);
    check_val("commit1.div1", 256'(divisor[63:32]), 256'(32'h0001_2345));

    xfer("wr_att1", 1'b1, 32'h3000_0028, 32'hFFFF_FFFF, 4'b0101);
    xfer("rd_att1", 1'b0, 32'h3000_0028, '0, 4'hF);
    check_val("rd_att1.value", 256'(dat_o), 256'(32'h00FF_00FF));
    xfer("commit_trig", 1'b1, 32'h3000_00E4, 32'h0000_0501, 4'hF);

    xfer("err_blk4", 1'b0, 32'h3000_0080, '0, 4'hF);
    xfer("err_wr_id", 1'b1, 32'h3000_00EC, 32'hDEAD_BEEF, 4'hF);
    xfer("err_base", 1'b1, 32'h3100_0000, 32'h1234_5678, 4'hF);
    xfer("err_gword", 1'b0, 32'h3000_00F4, '0, 4'hF);

    for (int i = 0; i < 250; i++) begin
      int k = int'($urandom_range(0, 9));
      logic [31:0] a;
      logic [31:0] d = $urandom;
      logic [3:0]  s = 4'($urandom);
      logic        w = ($urandom_range(0, 2) != 0);
      if (k <= 5)      a = {24'h30_0000, 3'($urandom_range(0, NV - 1)), 3'($urandom), 2'($urandom)};
      else if (k <= 7) a = {24'h30_0000, 3'd7, 1'b0, 2'($urandom), 2'b00};
      else if (k == 8) a = {24'h30_0000, 3'($urandom_range(NV, 7)), 3'($urandom), 2'b00};
      else             a = {8'h30, 16'($urandom_range(1, 65535)), 8'($urandom)};
      if (k == 6 && w) d[0] = ($urandom_range(0, 3) == 0);
      xfer("rand", w, a, d, s);
      if (i % 16 == 0) begin
        @(negedge clk) cyc = 1'b1;
        @(posedge clk); #1;
        check_val("cyc_only.resp", 256'({ack, err}), 256'(0));
        cyc = 1'b0;
      end
    end

    // Held strobe: one response every other cycle
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_00EC; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      check_val("held.ack", 256'(ack), 256'(i % 2));
      @(negedge clk);
    end
    stb = 1'b0; cyc = 1'b0;
    repeat (2) @(negedge clk);

    // Reset arriving while a request is pending
    xfer("pre_rst_wr", 1'b1, 32'h3000_00E8, 32'h0000_1234, 4'h3);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0000; dat_i = 32'hFFFF_FFFF; sel = 4'hF;
    #2 rst = 1'b1;
    #1 check_val("midrst.ack", 256'({ack, err}), 256'(0));
    model_reset();
    @(posedge clk); #1;
    check_val("midrst.resp", 256'({ack, err, dat_o, trigger}), 256'(0));
    check_outputs("midrst");
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    rst = 1'b0;
    xfer("post_rst_rd", 1'b0, 32'h3000_0000, '0, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/wishbone_voice_regs.md
Name: wishbone_voice_regs

Overview:
Parametrised Wishbone B4-classic slave register bank for the multi-voice synth. It replaces the single-voice register interface. It provides NUM_VOICES per-voice parameter sets, optional shadow registers with an atomic commit, self-clearing trigger pulses, an error response for unmapped addresses, and a read-only ID word. It sits between the Caravel Wishbone bus and the voice oscillators/envelopes/filters and the I2S transmitter.

Parameters:
NUM_VOICES, 4, number of voices (legal 1..7)
BASE_ADDR, 32'h3000_0000, slave base; adr[31:8] must equal BASE_ADDR[31:8]
SHADOW, 1, 1 = voice/CTRL writes land in shadow until commit; 0 = writes drive outputs directly
I2S_DIV_RESET, 16'd32, reset value of i2s_divisor

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
wbs_stb_i  in  1  strobe
wbs_cyc_i  in  1  cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  acknowledge
wbs_err_o  out  1  error acknowledge
wbs_dat_o  out  32  read data
divisor  out  32*NUM_VOICES  per-voice oscillator divisor, voice v at [32v+:32]
duty  out  8*NUM_VOICES  pulse duty
attack, decay, fade  out  27*NUM_VOICES each  envelope times
sustain  out  16*NUM_VOICES  sustain level
cutoff, resonance  out  18*NUM_VOICES each  filter coefficients
waveform  out  NUM_VOICES  waveform select per voice
trigger  out  NUM_VOICES  one-cycle note trigger pulse per voice
i2s_divisor  out  16  I2S bit-clock divisor

Behaviour:
- Address map: adr[7:5] = block, adr[4:2] = word, adr[1:0] ignored.
- Block v < NUM_VOICES, words 0..7: divisor, duty, attack, sustain, decay, fade, cutoff, resonance. Unused high bits read 0.
- Block 7, global:
  - 0xE0 CTRL: waveform[NUM_VOICES-1:0], shadowed.
  - 0xE4 CMD: write-only, reads 0. bit0 = commit, bits[8+v] = trigger voice v.
  - 0xE8 I2S_DIV: 16 bits, never shadowed.
  - 0xEC ID: read-only, value {16'h5359, 8'h00, 8'(NUM_VOICES)}.
- Unmapped: any of the following gives a response on wbs_err_o instead of wbs_ack_o, and no register changes:
  - block NUM_VOICES..6
  - global words 4..7
  - a write to ID
  - adr[31:8] mismatch
- Handshake:
  - Request = stb & cyc.
  - ack/err asserts in the cycle after the request is first seen, for exactly one cycle, then deasserts for at least one cycle (registered `ack <= req & ~ack & ~err`, same rule for err).
  - Held stb therefore yields one ack per two cycles.
  - ack and err are never high together.
  - stb dropped before the response: no response, no side effects.
- Writes: take effect at the same edge that raises ack, qualified per byte by wbs_sel_i. Fields narrower than a byte lane take only their implemented bits.
- Reads:
  - wbs_dat_o is loaded at the same edge and shows the pre-write value; shadow value when SHADOW=1.
  - wbs_dat_o = 0 with err.
  - Otherwise it holds its value between accesses.
- Shadow (SHADOW=1):
  - Voice and CTRL writes update shadow only.
  - Writing CMD with sel[0] and bit0=1 copies all shadows to outputs in one edge, so every output changes on the same cycle.
  - With SHADOW=0, commit is a no-op.
- Trigger: a CMD write with sel[1] and bit[8+v]=1 drives trigger[v] high for exactly one cycle, coincident with ack. It auto-clears with no bus activity.
- Commit + trigger in the same write: outputs update and trigger pulses on the same edge, so voices see new parameters with the trigger.
- Reset (async assert, sync release):
  - ack, err, dat_o, trigger, all shadow and output registers = 0.
  - i2s_divisor = I2S_DIV_RESET.
  - Reset mid-transaction aborts it with no response; the master must reissue.

Test Plan:
1. Reset, read 0xEC -> dat=32'h5359_0004, ack one cycle; read 0xE8 -> 32.
2. SHADOW=1: write 0x20 (voice1 divisor)=32'h0001_2345, sel=4'hF -> divisor[63:32] stays 0. Read 0x20 returns 32'h0001_2345. Write CMD=1 -> divisor[63:32]=32'h0001_2345 on the ack edge.
3. Write 0x28 (voice1 attack)=32'hFFFF_FFFF with sel=4'b0101 -> shadow attack = 27'h0FF_00FF, readback 32'h00FF_00FF.
4. Write CMD=32'h0000_0501 -> trigger=4'b0101 for exactly one cycle, same edge as outputs update; trigger=0 afterwards.
5. Access 0x80 (block 4, NUM_VOICES=4), a write to 0xEC, and adr 0x3100_0000 -> err one cycle, ack=0, dat=0, no register changed.
6. Hold stb/cyc for 6 cycles on a read -> ack pattern 0,1,0,1,0,1. Assert wb_rst_i mid-request -> ack low immediately, all outputs reset values.
